// File: rtl/uart_mmio_fifo.sv
// ============================================================================
// Module      : uart_mmio_fifo
// Description : Memory-mapped UART controller with TX/RX byte FIFOs.
//               Optional interrupt output and IRQ_EN register: UART_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio_fifo #(
  parameter logic [11:0] BASE_ADDR = 12'h800,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clock,
  input  logic        n_rst,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int c_TX_AW = $clog2(TX_DEPTH);
  localparam int c_RX_AW = $clog2(RX_DEPTH);
  localparam logic [c_TX_AW:0] c_TX_FULL = (c_TX_AW + 1)'(TX_DEPTH);
  localparam logic [c_RX_AW:0] c_RX_FULL = (c_RX_AW + 1)'(RX_DEPTH);
  localparam logic [c_TX_AW:0] c_TX_ONE  = (c_TX_AW + 1)'(1);
  localparam logic [c_RX_AW:0] c_RX_ONE  = (c_RX_AW + 1)'(1);
  localparam logic [11:0] c_A_STATUS = BASE_ADDR;
  localparam logic [11:0] c_A_TXDATA = BASE_ADDR + 12'd1;
  localparam logic [11:0] c_A_RXDATA = BASE_ADDR + 12'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;

  logic [7:0]         r_tx_mem [TX_DEPTH];
  logic [c_TX_AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [c_TX_AW:0]   r_tx_count;
  logic [7:0]         r_rx_mem [RX_DEPTH];
  logic [c_RX_AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [c_RX_AW:0]   r_rx_count;
  logic               r_rx_prev, r_rx_ovf, r_tx_ovf;
  logic [7:0]         r_tx_data;
  logic [15:0]        r_rdata;
  tx_state_t          r_state, w_state_next;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_tx_busy;
  logic w_sel_status, w_sel_tx, w_sel_rx;
  logic w_tx_pop, w_tx_push, w_tx_drop, w_tx_start;
  logic w_rx_pop, w_rx_push, w_rx_drop, w_rx_edge;
  logic [15:0] w_status;
  logic w_unused_wdata;

  assign w_sel_status = (addr == c_A_STATUS);
  assign w_sel_tx     = (addr == c_A_TXDATA);
  assign w_sel_rx     = (addr == c_A_RXDATA);

  assign w_tx_full  = (r_tx_count == c_TX_FULL);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == c_RX_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_busy  = ~w_tx_empty | (r_state != S_IDLE);

  // A same-cycle FSM pop frees the slot, so a push onto a full FIFO still lands.
  assign w_tx_push = we & w_sel_tx & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = we & w_sel_tx & w_tx_full & ~w_tx_pop;

  assign w_rx_edge = rx_ready & ~r_rx_prev;
  assign w_rx_pop  = re & w_sel_rx & ~w_rx_empty;
  assign w_rx_push = w_rx_edge & (~w_rx_full | w_rx_pop);
  assign w_rx_drop = w_rx_edge & w_rx_full & ~w_rx_pop;

  assign w_status = {8'(r_rx_count), 3'b000, w_tx_busy, r_tx_ovf, r_rx_ovf,
                     ~w_rx_empty, ~w_tx_full};

  assign w_unused_wdata = &{1'b0, wdata[15:8]};

  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    w_tx_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_start = 1'b1;
        if (!tx_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tx_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rptr];
    end
  end

  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_rx_prev  <= 1'b1;
      r_rx_ovf   <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      r_rx_prev <= rx_ready;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + c_TX_ONE;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - c_TX_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + c_RX_ONE;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - c_RX_ONE;
      // A new overflow event outranks a same-cycle W1C clear.
      if (w_rx_drop)                             r_rx_ovf <= 1'b1;
      else if (we && w_sel_status && wdata[2])   r_rx_ovf <= 1'b0;
      if (w_tx_drop)                             r_tx_ovf <= 1'b1;
      else if (we && w_sel_status && wdata[3])   r_tx_ovf <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  localparam logic [11:0] c_A_IRQEN = BASE_ADDR + 12'd3;
  logic       w_sel_irqen;
  logic [2:0] r_irq_en;
  logic       r_irq;

  assign w_sel_irqen = (addr == c_A_IRQEN);

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_irq_en <= 3'b000;
      r_irq    <= 1'b0;
    end else begin
      if (we && w_sel_irqen) r_irq_en <= wdata[2:0];
      r_irq <= (r_irq_en[0] & ~w_rx_empty)
             | (r_irq_en[1] & w_tx_empty & (r_state == S_IDLE))
             | (r_irq_en[2] & (r_rx_ovf | r_tx_ovf));
    end
  end

  assign irq = r_irq;
`endif

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r_rdata <= 16'h0000;
    end else if (re) begin
      if (w_sel_status)                r_rdata <= w_status;
      else if (w_sel_rx && !w_rx_empty) r_rdata <= {8'h00, r_rx_mem[r_rx_rptr]};
`ifdef UART_IRQ_EN
      else if (w_sel_irqen)            r_rdata <= {13'h0000, r_irq_en};
`endif
      else                             r_rdata <= 16'h0000;
    end
  end

  assign rdata    = r_rdata;
  assign tx_start = w_tx_start;
  assign tx_data  = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_fifo.sv
// ============================================================================
// Module      : tb_uart_mmio_fifo
// Description : Self-checking bench for uart_mmio_fifo (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio_fifo;

  localparam logic [11:0] c_STATUS = 12'h800;
  localparam logic [11:0] c_TXD    = 12'h801;
  localparam logic [11:0] c_RXD    = 12'h802;
  localparam logic [11:0] c_IRQEN  = 12'h803;
  localparam logic [1:0]  c_OP_WR  = 2'd0;
  localparam logic [1:0]  c_OP_RD  = 2'd1;
  localparam logic [1:0]  c_OP_RX  = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clock;
  logic        n_rst;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_ready;
  logic [7:0]  rx_data;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  int   tests = 0;
  int   fails = 0;
  int   rises = 0;
  logic model_en = 1'b0;
  logic ready_level = 1'b1;
  logic prev_start = 1'b0;
  logic [7:0] sent_q [$];
  vec_t vecs [19];

  uart_mmio_fifo #(
    .BASE_ADDR(12'h800),
    .TX_DEPTH (16),
    .RX_DEPTH (16)
  ) dut (
    .clock   (clock),
    .n_rst   (n_rst),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_ready(rx_ready),
    .rx_data (rx_data)
`ifdef UART_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // uart_tx stand-in: accepts a byte on tx_start, stays busy for 4 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (tx_start === 1'b1 && prev_start !== 1'b1) rises++;
      prev_start = tx_start;
      if (!model_en) begin
        tx_ready = ready_level;
      end else if (tx_start === 1'b1 && tx_ready) begin
        sent_q.push_back(tx_data);
        tx_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    cyc();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    logic [15:0] d;
    n_rst = 1'b0;
    repeat (2) cyc();
    check("reset_rdata", {16'h0, rdata}, 32'h0);
    check("reset_tx_start", {31'h0, tx_start}, 32'h0);
    n_rst = 1'b1;
    cyc();
    bus_read(c_STATUS, d);
    check("reset_status", {16'h0, d}, 32'h0001);
  endtask

  initial begin
    logic [15:0] d;
    n_rst = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    rx_ready = 1'b0; rx_data = '0;

    vecs[0]  = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0001};
    vecs[1]  = '{c_OP_WR, c_STATUS, 16'hFFFF, 16'h0000};
    vecs[2]  = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0001};
    vecs[3]  = '{c_OP_RX, 12'h000,  16'h00A5, 16'h0000};
    vecs[4]  = '{c_OP_RX, 12'h000,  16'h005A, 16'h0000};
    vecs[5]  = '{c_OP_RX, 12'h000,  16'h0000, 16'h0000};
    vecs[6]  = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0303};
    vecs[7]  = '{c_OP_RD, c_RXD,    16'h0000, 16'h00A5};
    vecs[8]  = '{c_OP_RD, c_RXD,    16'h0000, 16'h005A};
    vecs[9]  = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0103};
    vecs[10] = '{c_OP_RD, c_RXD,    16'h0000, 16'h0000};
    vecs[11] = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0001};
    vecs[12] = '{c_OP_RD, c_RXD,    16'h0000, 16'h0000};
    vecs[13] = '{c_OP_RD, c_STATUS, 16'h0000, 16'h0001};
    vecs[14] = '{c_OP_RD, 12'h804,  16'h0000, 16'h0000};
    vecs[15] = '{c_OP_RD, 12'h7FF,  16'h0000, 16'h0000};
    vecs[16] = '{c_OP_WR, c_IRQEN,  16'h0005, 16'h0000};
`ifdef UART_IRQ_EN
    vecs[17] = '{c_OP_RD, c_IRQEN,  16'h0000, 16'h0005};
`else
    vecs[17] = '{c_OP_RD, c_IRQEN,  16'h0000, 16'h0000};
`endif
    vecs[18] = '{c_OP_RD, c_TXD,    16'h0000, 16'h0000};

    do_reset();

    for (int i = 0; i < 19; i++) begin
      case (vecs[i].op)
        c_OP_WR: bus_write(vecs[i].addr, vecs[i].data);
        c_OP_RX: rx_pulse(vecs[i].data[7:0]);
        default: begin
          bus_read(vecs[i].addr, d);
          check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), {16'h0, d}, {16'h0, vecs[i].exp});
        end
      endcase
    end
    bus_write(c_IRQEN, 16'h0000);

    // Two TX bytes through the uart_tx stand-in.
    model_en = 1'b1;
    rises = 0;
    bus_write(c_TXD, 16'h0041);
    bus_write(c_TXD, 16'h0042);
    bus_read(c_STATUS, d);
    check("tx_busy_status", {16'h0, d}, 32'h0011);
    repeat (40) cyc();
    check("tx_start_rises", rises, 32'd2);
    check("tx_sent_count", sent_q.size(), 32'd2);
    if (sent_q.size() == 2) begin
      check("tx_byte0", {24'h0, sent_q[0]}, 32'h41);
      check("tx_byte1", {24'h0, sent_q[1]}, 32'h42);
    end
    bus_read(c_STATUS, d);
    check("tx_idle_status", {16'h0, d}, 32'h0001);

    // TX overflow with the core never ready; the first byte leaves for the FSM.
    model_en = 1'b0;
    ready_level = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 17; i++) bus_write(c_TXD, 16'(i));
    bus_read(c_STATUS, d);
    check("tx_full_status", {16'h0, d}, 32'h0010);
    bus_write(c_TXD, 16'h00FF);
    bus_read(c_STATUS, d);
    check("tx_ovf_status", {16'h0, d}, 32'h0018);
    bus_write(c_STATUS, 16'h0004);
    bus_read(c_STATUS, d);
    check("tx_ovf_wrong_w1c", {16'h0, d}, 32'h0018);
    bus_write(c_STATUS, 16'h0008);
    bus_read(c_STATUS, d);
    check("tx_ovf_cleared", {16'h0, d}, 32'h0010);

    // Reset mid-operation, then RX FIFO full corner cases.
    do_reset();
    ready_level = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'h10 + i));
    bus_read(c_STATUS, d);
    check("rx_full_status", {16'h0, d}, 32'h1003);
    rx_data = 8'hEE; rx_ready = 1'b1; addr = c_RXD; re = 1'b1;
    cyc();
    re = 1'b0; rx_ready = 1'b0;
    check("rx_simul_pop", {16'h0, rdata}, 32'h0010);
    cyc();
    bus_read(c_STATUS, d);
    check("rx_simul_status", {16'h0, d}, 32'h1003);
    rx_pulse(8'h77);
    bus_read(c_STATUS, d);
    check("rx_ovf_status", {16'h0, d}, 32'h1007);
    for (int i = 1; i < 16; i++) begin
      bus_read(c_RXD, d);
      check($sformatf("rx_drain%0d", i), {16'h0, d}, 32'(16'h0010 + i));
    end
    bus_read(c_RXD, d);
    check("rx_drain_last", {16'h0, d}, 32'h00EE);
    repeat (2) cyc();
    check("rdata_hold", {16'h0, rdata}, 32'h00EE);
    bus_read(c_STATUS, d);
    check("rx_empty_ovf", {16'h0, d}, 32'h0005);
    bus_write(c_STATUS, 16'h0008);
    bus_read(c_STATUS, d);
    check("rx_ovf_wrong_w1c", {16'h0, d}, 32'h0005);
    bus_write(c_STATUS, 16'h0004);
    bus_read(c_STATUS, d);
    check("rx_ovf_cleared", {16'h0, d}, 32'h0001);

`ifdef UART_IRQ_EN
    bus_write(c_IRQEN, 16'h0001);
    cyc();
    check("irq_idle", {31'h0, irq}, 32'h0);
    rx_data = 8'h33; rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
    check("irq_push_cycle", {31'h0, irq}, 32'h0);
    cyc();
    check("irq_after_push", {31'h0, irq}, 32'h1);
    addr = c_RXD; re = 1'b1;
    cyc();
    re = 1'b0;
    check("irq_pop_rdata", {16'h0, rdata}, 32'h0033);
    cyc();
    check("irq_after_pop", {31'h0, irq}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
